// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the address/control payload used by the arbiter.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'b000,
      HSIZE_HALF  = 3'b001,
      HSIZE_WORD  = 3'b010,
      HSIZE_DWORD = 3'b011
   } hsize_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_INCR4  = 3'b011
   } hburst_e;

   // Address-phase control fields that travel together through the mux.
   typedef struct packed {
      logic [1:0] trans;
      logic [2:0] size;
      logic [2:0] burst;
      logic       write;
   } ahb_ctrl_t;

   // SEQ and BUSY both mean the master is inside a burst that must not be split.
   function automatic logic is_burst(input logic [1:0] trans);
      return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
   endfunction

endpackage

// File: rtl/ahb_arb2_gnt.sv
// Grant owner and per-grant quota counter with preempt/handover decode.
module ahb_arb2_gnt
   import ahb_pkg::*;
#(
   parameter int unsigned QUOTA = 4
) (
   input  logic       hclk,
   input  logic       hresetn,
   input  logic [1:0] m0_htrans,
   input  logic [1:0] m1_htrans,
   input  logic       s_hready,
   output logic       gnt,
   output logic       preempt_c
);

   localparam int unsigned QW = 4;
   localparam logic [QW-1:0] QMAX = QW'(QUOTA);

   logic [QW-1:0] qcnt;
   logic [QW-1:0] qcnt_nxt;
   logic          gnt_nxt;
   logic [1:0]    cur;
   logic [1:0]    oth;
   logic          oreq;
   logic          burst;
   logic          handover;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         gnt  <= 1'b0;
         qcnt <= '0;
      end else begin
         gnt  <= gnt_nxt;
         qcnt <= qcnt_nxt;
      end
   end

   // Preempt forces the owner's NONSEQ off the bus; that IDLE is the handover cost.
   always_comb begin
      cur       = gnt ? m1_htrans : m0_htrans;
      oth       = gnt ? m0_htrans : m1_htrans;
      oreq      = oth[1];
      burst     = is_burst(cur);
      preempt_c = (cur == HTRANS_NONSEQ) && oreq && (qcnt == QMAX);
      handover  = s_hready && !burst && !preempt_c && (cur == HTRANS_IDLE) && oreq;
      gnt_nxt   = gnt;
      qcnt_nxt  = qcnt;
      if (s_hready) begin
         if (preempt_c || handover) begin
            gnt_nxt  = ~gnt;
            qcnt_nxt = '0;
         end else if ((cur == HTRANS_NONSEQ) && oreq) begin
            if (qcnt != QMAX) qcnt_nxt = qcnt + QW'(1);
         end else if (!oreq) begin
            qcnt_nxt = '0;
         end
      end
   end

endmodule

// File: rtl/ahb_arb2.sv
// Two-master AHB-lite arbiter: address mux, data-phase ownership and per-master response steering.
module ahb_arb2
   import ahb_pkg::*;
#(
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned QUOTA = 4
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic [AW-1:0] m0_haddr,
   input  logic [1:0]    m0_htrans,
   input  logic [2:0]    m0_hsize,
   input  logic [2:0]    m0_hburst,
   input  logic          m0_hwrite,
   input  logic [DW-1:0] m0_hwdata,
   input  logic [AW-1:0] m1_haddr,
   input  logic [1:0]    m1_htrans,
   input  logic [2:0]    m1_hsize,
   input  logic [2:0]    m1_hburst,
   input  logic          m1_hwrite,
   input  logic [DW-1:0] m1_hwdata,
   output logic          m0_hready,
   output logic          m0_hresp,
   output logic          m1_hready,
   output logic          m1_hresp,
   output logic [DW-1:0] m_hrdata,
   output logic [AW-1:0] s_haddr,
   output logic [1:0]    s_htrans,
   output logic [2:0]    s_hsize,
   output logic [2:0]    s_hburst,
   output logic          s_hwrite,
   output logic [DW-1:0] s_hwdata,
   input  logic [DW-1:0] s_hrdata,
   input  logic          s_hready,
   input  logic          s_hresp,
   output logic          gnt
);

   logic      preempt_c;
   logic      dvalid;
   logic      downer;
   ahb_ctrl_t m0_ctrl;
   ahb_ctrl_t m1_ctrl;
   ahb_ctrl_t sel_ctrl;

   ahb_arb2_gnt #(.QUOTA(QUOTA)) u_gnt (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .m0_htrans (m0_htrans),
      .m1_htrans (m1_htrans),
      .s_hready  (s_hready),
      .gnt       (gnt),
      .preempt_c (preempt_c)
   );

   assign m0_ctrl = '{trans: m0_htrans, size: m0_hsize, burst: m0_hburst, write: m0_hwrite};
   assign m1_ctrl = '{trans: m1_htrans, size: m1_hsize, burst: m1_hburst, write: m1_hwrite};
   assign sel_ctrl = gnt ? m1_ctrl : m0_ctrl;

   // Address phase follows the grant; reset and preempt both present IDLE to the slave.
   assign s_haddr  = gnt ? m1_haddr : m0_haddr;
   assign s_htrans = (!hresetn || preempt_c) ? HTRANS_IDLE : sel_ctrl.trans;
   assign s_hsize  = sel_ctrl.size;
   assign s_hburst = sel_ctrl.burst;
   assign s_hwrite = sel_ctrl.write;

   assign s_hwdata = downer ? m1_hwdata : m0_hwdata;
   assign m_hrdata = s_hrdata;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dvalid <= 1'b0;
         downer <= 1'b0;
      end else if (s_hready) begin
         dvalid <= s_htrans[1];
         downer <= gnt;
      end
   end

   // Data-phase owner sees the slave first; a waiting requester is stalled.
   always_comb begin
      m0_hready = 1'b0;
      m1_hready = 1'b0;
      if (dvalid && !downer)      m0_hready = s_hready;
      else if (!gnt && !preempt_c) m0_hready = s_hready;
      else if (!m0_htrans[1])      m0_hready = 1'b1;
      if (dvalid && downer)       m1_hready = s_hready;
      else if (gnt && !preempt_c)  m1_hready = s_hready;
      else if (!m1_htrans[1])      m1_hready = 1'b1;
   end

   assign m0_hresp = (dvalid && !downer) ? s_hresp : HRESP_OKAY;
   assign m1_hresp = (dvalid &&  downer) ? s_hresp : HRESP_OKAY;

endmodule
